timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Control stage directly upstream of the down-counting timer (`timer_p`). It arms the timer with a latched period and issues the `start` pulse. A programmable prescaler generates the `en` strobes. The block watches `done`, counts expirations and raises a sticky interrupt, in either one-shot or auto-reload (periodic) mode.

## Interface
- `WIDTH`, 8, timer width; must match the downstream timer.
- `PRESCALE_W`, 8, width of the prescaler compare value.
- `COUNT_W`, 8, width of the expiration counter.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  single-cycle request; latches the configuration and starts a run; only acted on in IDLE.
- `abort`  in  1  single-cycle request; returns to IDLE from any state.
- `cfg_period`  in  WIDTH  timer load value, in prescaled ticks.
- `cfg_prescale`  in  PRESCALE_W  tick divider; one `en` per cfg_prescale+1 clocks.
- `cfg_periodic`  in  1  1 = auto-reload, 0 = one-shot.
- `irq_ack`  in  1  clears `irq`.
- `tmr_done`  in  1  from the timer's `done`.
- `tmr_start`  out  1  to the timer's `start`.
- `tmr_en`  out  1  to the timer's `en`.
- `tmr_init_val`  out  WIDTH  to the timer's `init_val`.
- `busy`  out  1  state != IDLE.
- `irq`  out  1  sticky expiration flag.
- `expire_count`  out  COUNT_W  number of expirations since the last arm.

## Operation
- **Reset:** all registers clear; state IDLE. `tmr_start`, `tmr_en`, `tmr_init_val`, `busy`, `irq` and `expire_count` are all 0.
- **Shadow registers:** `period_q`, `prescale_q` and `periodic_q` are captured only when `arm` is accepted. The shadow registers alone drive behaviour until the next arm. `tmr_init_val` = `period_q`.
- **IDLE**
  - `arm` and not `abort`: capture the shadow registers, clear `expire_count`, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD (1 cycle)**
  - `tmr_start` = 1; the prescaler counter `pre_cnt` is cleared.
  - Next state is RUN.
- **RUN**
  - `pre_cnt` counts 0..`prescale_q` and wraps to 0.
  - `tmr_en` = (`pre_cnt` == `prescale_q`) && !`tmr_done`.
  - `tmr_done` = 1: go to EXPIRE; `tmr_en` is 0 in that cycle.
- **EXPIRE (1 cycle)**
  - Set `irq`.
  - Increment `expire_count`, saturating at all-ones.
  - Next state is LOAD if `periodic_q`, else IDLE.
- **abort:** any state goes to IDLE on the next edge, with priority over `arm` and over the EXPIRE side effects.
  - In EXPIRE with `abort`: no `irq` set, no count.
  - In LOAD with `abort`: the timer still loads (`tmr_start` was already high), but no `en` follows.
- **arm outside IDLE:** ignored. The shadow registers are unchanged.
- **irq:** a set and an `irq_ack` in the same cycle leave `irq` = 1 (set wins).
- **Edge case `period_q` = 0:** RUN lasts exactly 1 cycle, then EXPIRE.
- **Edge case `prescale_q` = 0:** `tmr_en` is asserted every RUN cycle until done.

## Timing
- `tmr_start`, `busy` and `tmr_init_val` are decoded purely from registers.
- `tmr_en` additionally depends on `tmr_done`, which is itself register-derived in the timer, so there is no combinational loop.
- The timer sees `remaining` = `period_q` in the first RUN cycle, so a stale `done` from a previous run cannot be sampled.
- Cycle timeline, with `arm` sampled at the end of cycle 0, P = `period_q`, S = `prescale_q`:
  - LOAD in cycle 1.
  - RUN in cycles 2 .. 2+P(S+1).
  - EXPIRE in cycle 3+P(S+1).
  - `irq` and the new `expire_count` are visible from cycle 4+P(S+1).
- Periodic mode: expirations are spaced exactly P(S+1)+3 cycles apart.
- Reset asserted mid-run: outputs return to their reset values asynchronously. After deassertion the block sits in IDLE until the next `arm`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN (P=10, S=3). All outputs go to 0 immediately; the block stays IDLE after release with no `tmr_en`.
- **One-shot:** P=5, S=1, `arm` in cycle 0.
  - `tmr_start` is high in cycle 1 only.
  - `tmr_en` pulses in cycles 3, 5, 7, 9, 11.
  - EXPIRE in cycle 13; `irq`=1 and `expire_count`=1 from cycle 14; `busy`=0 from cycle 14.
- **Periodic with saturation:** P=2, S=0, COUNT_W=2.
  - Expirations occur every 5 cycles.
  - `expire_count` reads 1, 2, 3, 3.
  - Pulse `irq_ack` in the same cycle as the second expiration's set; `irq` stays 1.
- **Zero period:** P=0, S=7.
  - `tmr_en` never asserts.
  - EXPIRE in cycle 3; `irq` in cycle 4.
  - Periodic repeats every 3 cycles.
- **Abort and arm priority:**
  - `abort` in the EXPIRE cycle: IDLE next, `irq` stays 0, count unchanged.
  - `arm`+`abort` together in IDLE: stays IDLE.
  - `arm` during RUN with a new `cfg_period`: ignored; the next reload still uses the old P.
- **Config isolation:** change `cfg_prescale` and `cfg_periodic` during RUN. The `tmr_en` spacing and the reload decision still follow the values latched at arm.

Source files
------------

// File: rtl/timer_ctrl.sv
// Arms a down-counting timer with a latched period, paces it with a prescaled enable and counts its expirations.
// tmr_start one cycle after an accepted arm; no backpressure: arm is dropped outside IDLE, abort always wins.
module timer_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8,
    parameter int COUNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_periodic,
    input  logic                  irq_ack,
    input  logic                  tmr_done,
    output logic                  tmr_start,
    output logic                  tmr_en,
    output logic [WIDTH-1:0]      tmr_init_val,
    output logic                  busy,
    output logic                  irq,
    output logic [COUNT_W-1:0]    expire_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        EXPIRE = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [WIDTH-1:0]      period_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  periodic_q;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  irq_q;
    logic [COUNT_W-1:0]    count_q;

    logic arm_accept;
    logic expire_commit;
    logic pre_wrap;

    assign arm_accept    = (state_q == IDLE) && arm && !abort;
    // An abort landing on EXPIRE discards that expiration entirely.
    assign expire_commit = (state_q == EXPIRE) && !abort;
    assign pre_wrap      = (pre_cnt == prescale_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (tmr_done) state_d = EXPIRE;
            EXPIRE:  state_d = periodic_q ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        tmr_start    = 1'b0;
        tmr_en       = 1'b0;
        busy         = 1'b0;
        tmr_init_val = period_q;
        irq          = irq_q;
        expire_count = count_q;
        if (state_q == LOAD) begin
            tmr_start = 1'b1;
        end
        // The done term keeps en low in the cycle the timer reports expiry.
        if (state_q == RUN) begin
            tmr_en = pre_wrap && !tmr_done;
        end
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
        end else if (arm_accept) begin
            period_q   <= cfg_period;
            prescale_q <= cfg_prescale;
            periodic_q <= cfg_periodic;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (state_q == LOAD) begin
            pre_cnt <= '0;
        end else if (state_q == RUN) begin
            pre_cnt <= pre_wrap ? '0 : pre_cnt + PRESCALE_W'(1);
        end
    end

    // A set in the same cycle as an acknowledge takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (expire_commit) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (arm_accept) begin
            count_q <= '0;
        end else if (expire_commit && (count_q != '1)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural down-counter standing in for the timer.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm;
    logic       abort;
    logic [7:0] cfg_period;
    logic [7:0] cfg_prescale;
    logic       cfg_periodic;
    logic       irq_ack;
    logic       tmr_done;
    logic       tmr_start;
    logic       tmr_en;
    logic [7:0] tmr_init_val;
    logic       busy;
    logic       irq;
    logic [1:0] expire_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] rem = 8'd0;

    timer_ctrl #(.WIDTH(8), .PRESCALE_W(8), .COUNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .cfg_period   (cfg_period),
        .cfg_prescale (cfg_prescale),
        .cfg_periodic (cfg_periodic),
        .irq_ack      (irq_ack),
        .tmr_done     (tmr_done),
        .tmr_start    (tmr_start),
        .tmr_en       (tmr_en),
        .tmr_init_val (tmr_init_val),
        .busy         (busy),
        .irq          (irq),
        .expire_count (expire_count)
    );

    always #5 clk = ~clk;

    // Downstream timer: load on start, count down on en, done while at zero.
    always @(posedge clk) begin
        if (tmr_start) rem <= tmr_init_val;
        else if (tmr_en && rem != 8'd0) rem <= rem - 8'd1;
    end
    assign tmr_done = (rem == 8'd0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ack_irq;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_abort;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset;
        logic bad;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({tmr_start, tmr_en, busy, irq} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {tmr_start, tmr_en, busy, irq});
        end
        checks++;
        if (tmr_init_val !== 8'd0 || expire_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_values got init %0d cnt %0d want 0 0", tmr_init_val, expire_count);
        end
        rst_n = 1'b1;
        tick();
        cfg_period = 8'd10; cfg_prescale = 8'd3; cfg_periodic = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        checks++;
        if (busy !== 1'b1 || tmr_init_val !== 8'd10) begin
            errors++;
            $display("FAIL midrun_pre_reset got busy %b init %0d want 1 10", busy, tmr_init_val);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tmr_start, tmr_en, busy, irq} !== 4'b0000 || tmr_init_val !== 8'd0 || expire_count !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got flags %b init %0d cnt %0d want 0", {tmr_start, tmr_en, busy, irq}, tmr_init_val, expire_count);
        end
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (tmr_en !== 1'b0 || busy !== 1'b0 || tmr_start !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got activity %b want 0", bad);
        end
    endtask

    task automatic test_one_shot;
        logic exp_en;
        cfg_period = 8'd5; cfg_prescale = 8'd1; cfg_periodic = 1'b0; arm = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            arm = 1'b0;
            exp_en = (c == 3 || c == 5 || c == 7 || c == 9 || c == 11);
            checks++;
            if (tmr_start !== (c == 1)) begin
                errors++;
                $display("FAIL oneshot_start c%0d got %b want %b", c, tmr_start, (c == 1));
            end
            checks++;
            if (tmr_en !== exp_en) begin
                errors++;
                $display("FAIL oneshot_en c%0d got %b want %b", c, tmr_en, exp_en);
            end
            checks++;
            if (busy !== (c <= 13) || irq !== (c >= 14)) begin
                errors++;
                $display("FAIL oneshot_busy_irq c%0d got %b%b want %b%b", c, busy, irq, (c <= 13), (c >= 14));
            end
            checks++;
            if (expire_count !== ((c >= 14) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL oneshot_count c%0d got %0d want %0d", c, expire_count, (c >= 14) ? 1 : 0);
            end
        end
        checks++;
        if (tmr_init_val !== 8'd5) begin
            errors++;
            $display("FAIL oneshot_init got %0d want 5", tmr_init_val);
        end
        ack_irq();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack got %b want 0", irq);
        end
    endtask

    task automatic test_periodic_sat;
        logic [1:0] exp_cnt;
        logic       exp_irq;
        logic       exp_en;
        cfg_period = 8'd2; cfg_prescale = 8'd0; cfg_periodic = 1'b1; arm = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            arm = 1'b0;
            exp_cnt = (c < 6) ? 2'd0 : (c < 11) ? 2'd1 : (c < 16) ? 2'd2 : 2'd3;
            exp_irq = (c >= 6 && c <= 7) || (c >= 11);
            exp_en  = (c % 5 == 2) || (c % 5 == 3);
            checks++;
            if (expire_count !== exp_cnt) begin
                errors++;
                $display("FAIL periodic_count c%0d got %0d want %0d", c, expire_count, exp_cnt);
            end
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL periodic_irq c%0d got %b want %b", c, irq, exp_irq);
            end
            checks++;
            if (tmr_start !== (c % 5 == 1) || tmr_en !== exp_en || busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_ctl c%0d got start %b en %b busy %b want %b %b 1", c, tmr_start, tmr_en, busy, (c % 5 == 1), exp_en);
            end
            irq_ack = (c == 7 || c == 10);
        end
        irq_ack = 1'b0;
        do_abort();
        checks++;
        if (busy !== 1'b0 || expire_count !== 2'd3) begin
            errors++;
            $display("FAIL periodic_abort got busy %b cnt %0d want 0 3", busy, expire_count);
        end
        ack_irq();
    endtask

    task automatic test_zero_period;
        logic [1:0] exp_cnt;
        cfg_period = 8'd0; cfg_prescale = 8'd7; cfg_periodic = 1'b0; arm = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            arm = 1'b0;
            checks++;
            if (tmr_start !== (c == 1) || tmr_en !== 1'b0 || busy !== (c <= 3) || irq !== (c >= 4)) begin
                errors++;
                $display("FAIL zero_oneshot c%0d got start %b en %b busy %b irq %b", c, tmr_start, tmr_en, busy, irq);
            end
        end
        ack_irq();
        cfg_periodic = 1'b1; arm = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            arm = 1'b0;
            exp_cnt = (c < 4) ? 2'd0 : (c < 7) ? 2'd1 : (c < 10) ? 2'd2 : 2'd3;
            checks++;
            if (tmr_start !== (c % 3 == 1) || tmr_en !== 1'b0 || expire_count !== exp_cnt) begin
                errors++;
                $display("FAIL zero_periodic c%0d got start %b en %b cnt %0d want %b 0 %0d", c, tmr_start, tmr_en, expire_count, (c % 3 == 1), exp_cnt);
            end
        end
        do_abort();
        ack_irq();
    endtask

    task automatic test_abort_arm;
        cfg_period = 8'd0; cfg_prescale = 8'd0; cfg_periodic = 1'b1; arm = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            arm = 1'b0;
            if (c == 5) begin
                checks++;
                if (irq !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_pre_ack got %b want 0", irq);
                end
            end
            if (c == 7) begin
                checks++;
                if (busy !== 1'b0 || irq !== 1'b0 || expire_count !== 2'd1) begin
                    errors++;
                    $display("FAIL abort_in_expire got busy %b irq %b cnt %0d want 0 0 1", busy, irq, expire_count);
                end
            end
            irq_ack = (c == 4);
            abort   = (c == 6);
        end
        irq_ack = 1'b0; abort = 1'b0;
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || tmr_start !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort_idle got busy %b start %b want 0 0", busy, tmr_start);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tmr_start !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort_idle2 got busy %b start %b want 0 0", busy, tmr_start);
        end
        cfg_period = 8'd3; cfg_prescale = 8'd0; cfg_periodic = 1'b1; arm = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            arm = 1'b0;
            checks++;
            if (tmr_start !== (c == 1 || c == 7 || c == 13)) begin
                errors++;
                $display("FAIL arm_in_run_start c%0d got %b want %b", c, tmr_start, (c == 1 || c == 7 || c == 13));
            end
            if (c == 8) begin
                checks++;
                if (tmr_init_val !== 8'd3) begin
                    errors++;
                    $display("FAIL arm_in_run_init got %0d want 3", tmr_init_val);
                end
            end
            if (c == 13) begin
                checks++;
                if (expire_count !== 2'd2) begin
                    errors++;
                    $display("FAIL arm_in_run_count got %0d want 2", expire_count);
                end
            end
            if (c == 3) begin
                cfg_period = 8'd9;
                arm = 1'b1;
            end
        end
        do_abort();
        ack_irq();
    endtask

    task automatic test_config_isolation;
        logic exp_en;
        cfg_period = 8'd2; cfg_prescale = 8'd2; cfg_periodic = 1'b1; arm = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            arm = 1'b0;
            exp_en = (c == 4 || c == 7 || c == 13);
            checks++;
            if (tmr_en !== exp_en || tmr_start !== (c == 1 || c == 10)) begin
                errors++;
                $display("FAIL cfg_iso c%0d got en %b start %b want %b %b", c, tmr_en, tmr_start, exp_en, (c == 1 || c == 10));
            end
            if (c == 10) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL cfg_iso_reload got busy %b want 1", busy);
                end
            end
            if (c == 3) begin
                cfg_prescale = 8'd0;
                cfg_periodic = 1'b0;
            end
        end
        do_abort();
        ack_irq();
    endtask

    initial begin
        arm = 1'b0; abort = 1'b0; irq_ack = 1'b0;
        cfg_period = 8'd0; cfg_prescale = 8'd0; cfg_periodic = 1'b0;
        test_reset();
        test_one_shot();
        test_periodic_sat();
        test_zero_period();
        test_abort_arm();
        test_config_isolation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
